// File: rtl/noc_pkt_pkg.sv
// PE NoC packet field layout, node addresses and packet type.
// Shared by the PE depacketizer and the PE packetizer.
package noc_pkt_pkg;

   localparam int TYPE_BIT  = 46;
   localparam int DEST_MSB  = 45;
   localparam int DEST_LSB  = 43;
   localparam int SRC_MSB   = 42;
   localparam int SRC_LSB   = 40;
   localparam int PAYLOAD_W = 40;

   localparam logic [2:0] ADDR_PE0   = 3'b011;
   localparam logic [2:0] ADDR_PE1   = 3'b001;
   localparam logic [2:0] ADDR_PE2   = 3'b000;
   localparam logic [2:0] ADDR_ADDER = 3'b100;

   typedef enum logic {
      PKT_FILT = 1'b0,
      PKT_IFM  = 1'b1
   } pkt_type_e;

   function automatic logic [2:0] pe_addr(input int idx);
      case (idx)
         0:       pe_addr = ADDR_PE0;
         1:       pe_addr = ADDR_PE1;
         default: pe_addr = ADDR_PE2;
      endcase
   endfunction

endpackage

// File: rtl/d_pe_ifm_serializer.sv
// Holds the captured payload and walks it out one activation per
// handshake, element 0 first; done pulses on the last handshake.
module d_pe_ifm_serializer
   import noc_pkt_pkg::*;
#(
   parameter int DWIDTH      = 8,
   parameter int IFM_PER_PKT = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [PAYLOAD_W-1:0] load_payload,
   input  logic                 active,
   input  logic                 ifm_ready,
   output logic                 ifm_valid,
   output logic [DWIDTH-1:0]    ifm_data,
   output logic                 ifm_last,
   output logic                 done,
   output logic [PAYLOAD_W-1:0] payload
);

   localparam int KW = (IFM_PER_PKT > 1) ? $clog2(IFM_PER_PKT) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(IFM_PER_PKT - 1);

   logic [PAYLOAD_W-1:0] payload_q;
   logic [KW-1:0]        k_q;
   logic                 hs;
   logic                 at_last;

   assign hs        = active && ifm_ready;
   assign at_last   = (k_q == K_LAST);
   assign done      = hs && at_last;
   assign ifm_valid = active;
   assign ifm_last  = active && at_last;
   assign payload   = payload_q;

   always_comb begin
      ifm_data = '0;
      if (active)
         ifm_data = payload_q[int'(k_q)*DWIDTH +: DWIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         payload_q <= '0;
         k_q       <= '0;
      end else begin
         if (load)
            payload_q <= load_payload;
         if (done)
            k_q <= '0;
         else if (hs)
            k_q <= k_q + 1'b1;
      end
   end

endmodule

// File: rtl/d_pe_depacketizer.sv
// PE NoC receive port: decodes router packets into filter frames or
// activation streams. Optional dest check under DPE_ADDR_CHECK_EN.
module d_pe_depacketizer
   import noc_pkt_pkg::*;
#(
   parameter int DWIDTH      = 8,
   parameter int PWIDTH      = 47,
   parameter int PE_INDEX    = 0,
   parameter int IFM_PER_PKT = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [PWIDTH-1:0]   in_pkt,
   output logic                filt_valid,
   input  logic                filt_ready,
   output logic [3*DWIDTH-1:0] filt_data,
   output logic                ifm_valid,
   input  logic                ifm_ready,
   output logic [DWIDTH-1:0]   ifm_data,
   output logic                ifm_last,
   output logic [2:0]          pkt_src,
   output logic                addr_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILT = 2'd1,
      IFM  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic                 in_ready_q;
   logic [2:0]           src_q;
   logic                 accept;
   logic                 addr_ok;
   logic                 load;
   logic                 ifm_done;
   logic [PAYLOAD_W-1:0] payload;
   pkt_type_e            pkt_type;
   logic [2:0]           dest;

   assign pkt_type = pkt_type_e'(in_pkt[TYPE_BIT]);
   assign dest     = in_pkt[DEST_MSB:DEST_LSB];
   assign accept   = in_valid && in_ready_q;

`ifdef DPE_ADDR_CHECK_EN
   localparam logic [2:0] THIS_ADDR = pe_addr(PE_INDEX);
   logic addr_err_q;

   assign addr_ok  = (dest == THIS_ADDR);
   assign addr_err = addr_err_q;

   always_ff @(posedge clk) begin
      if (rst)
         addr_err_q <= 1'b0;
      else if (accept && !addr_ok)
         addr_err_q <= 1'b1;
   end
`else
   logic unused_cfg;

   assign addr_ok    = 1'b1;
   assign addr_err   = 1'b0;
   assign unused_cfg = ^{dest, pe_addr(PE_INDEX)};
`endif

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept && addr_ok) begin
               load    = 1'b1;
               state_d = (pkt_type == PKT_IFM) ? IFM : FILT;
            end
         end
         FILT: if (filt_ready) state_d = IDLE;
         IFM:  if (ifm_done)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // in_ready mirrors the next state so it is a plain flop output
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
         src_q      <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d == IDLE);
         if (load)
            src_q <= in_pkt[SRC_MSB:SRC_LSB];
      end
   end

   d_pe_ifm_serializer #(
      .DWIDTH      (DWIDTH),
      .IFM_PER_PKT (IFM_PER_PKT)
   ) u_ser (
      .clk          (clk),
      .rst          (rst),
      .load         (load),
      .load_payload (in_pkt[PAYLOAD_W-1:0]),
      .active       (state_q == IFM),
      .ifm_ready    (ifm_ready),
      .ifm_valid    (ifm_valid),
      .ifm_data     (ifm_data),
      .ifm_last     (ifm_last),
      .done         (ifm_done),
      .payload      (payload)
   );

   logic unused_payload;

   assign in_ready       = in_ready_q;
   assign pkt_src        = src_q;
   assign filt_valid     = (state_q == FILT);
   assign filt_data      = filt_valid ? payload[3*DWIDTH-1:0] : '0;
   assign unused_payload = ^payload[PAYLOAD_W-1:3*DWIDTH];

endmodule

// File: tb/tb_d_pe_depacketizer.sv
// Bench for d_pe_depacketizer: vector table, corner sequences and
// random traffic against a queue-based packet model.
module tb_d_pe_depacketizer;

   localparam int DW = 8;
   localparam int PW = 47;
   localparam int NK = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [PW-1:0] in_pkt = '0;
   logic          filt_valid;
   logic          filt_ready = 1'b0;
   logic [23:0]   filt_data;
   logic          ifm_valid;
   logic          ifm_ready = 1'b0;
   logic [7:0]    ifm_data;
   logic          ifm_last;
   logic [2:0]    pkt_src;
   logic          addr_err;

   int checks = 0;
   int failures = 0;
   int mode = 0;
   int hs_cnt = 0;

   always #5 clk = ~clk;

   d_pe_depacketizer #(
      .DWIDTH(DW), .PWIDTH(PW), .PE_INDEX(0), .IFM_PER_PKT(NK)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
      .filt_valid(filt_valid), .filt_ready(filt_ready),
      .filt_data(filt_data),
      .ifm_valid(ifm_valid), .ifm_ready(ifm_ready),
      .ifm_data(ifm_data), .ifm_last(ifm_last),
      .pkt_src(pkt_src), .addr_err(addr_err)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: bound expired", nm);
   endtask

   function automatic logic [PW-1:0] mk(input logic t, input logic [2:0] d,
                                        input logic [2:0] s,
                                        input logic [39:0] pl);
      return {t, d, s, pl};
   endfunction

   // expected output items, in order, for packets already accepted
   typedef struct {
      logic       ifm;
      logic [23:0] data;
      logic       last;
      logic [2:0] src;
   } item_t;

   item_t q[$];
   logic  prev_rst = 1'b1;
   logic  exp_aerr = 1'b0;

   function automatic void model_accept(input logic [PW-1:0] p);
      logic [39:0] pl;
      item_t it;
      pl = p[39:0];
`ifdef DPE_ADDR_CHECK_EN
      if (p[45:43] != 3'b011) begin
         exp_aerr = 1'b1;
         return;
      end
`endif
      it.src = p[42:40];
      if (p[46] == 1'b0) begin
         it.ifm = 1'b0;
         it.data = pl % (40'd1 << 24);
         it.last = 1'b0;
         q.push_back(it);
      end else begin
         for (int i = 0; i < NK; i++) begin
            it.ifm = 1'b1;
            it.data = (pl / (40'd1 << (8 * i))) % 40'd256;
            it.last = (i == NK - 1);
            q.push_back(it);
         end
      end
   endfunction

   always @(negedge clk) begin
      item_t it;
      if (rst) begin
         q.delete();
         exp_aerr = 1'b0;
         prev_rst = 1'b1;
      end else begin
         if (prev_rst) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_valids", {filt_valid, ifm_valid, ifm_last}, 0);
            chk("rst_data", {filt_data, ifm_data, pkt_src}, 0);
         end else begin
            chk("in_ready", in_ready, q.size() == 0);
         end
         chk("overlap", filt_valid && ifm_valid, 0);
         chk("addr_err", addr_err, exp_aerr);
         if (q.size() == 0) begin
            chk("idle_valids", {filt_valid, ifm_valid}, 0);
         end else begin
            it = q[0];
            chk("filt_valid", filt_valid, !it.ifm);
            chk("ifm_valid", ifm_valid, it.ifm);
            chk("pkt_src", pkt_src, it.src);
            if (it.ifm) begin
               chk("ifm_data", ifm_data, it.data[7:0]);
               chk("ifm_last", ifm_last, it.last);
               if (ifm_valid && ifm_ready) begin
                  void'(q.pop_front());
                  hs_cnt++;
               end
            end else begin
               chk("filt_data", filt_data, it.data);
               if (filt_valid && filt_ready)
                  void'(q.pop_front());
            end
         end
         if (in_valid && in_ready)
            model_accept(in_pkt);
         prev_rst = 1'b0;
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      case (mode)
         0: begin filt_ready = 1'b1; ifm_ready = 1'b1; end
         1: begin filt_ready = ~filt_ready; ifm_ready = ~ifm_ready; end
         default: begin
            filt_ready = 1'($urandom_range(0, 1));
            ifm_ready  = 1'($urandom_range(0, 1));
         end
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [PW-1:0] p);
      int n;
      n = 0;
      in_pkt = p;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) fail("send_timeout");
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) fail("drain_timeout");
      tick();
   endtask

   typedef struct {
      logic [PW-1:0] pkt;
      logic          is_ifm;
      logic [39:0]   exp;
      logic [2:0]    src;
   } vec_t;

`ifdef DPE_ADDR_CHECK_EN
   localparam logic [2:0] ALT_DEST = 3'b011;
`else
   localparam logic [2:0] ALT_DEST = 3'b001;
`endif

   vec_t vecs[5];

   initial begin
      int h0;
      logic [39:0] pl;
      logic [2:0] dst;

      vecs[0] = '{mk(0, 3'b011, 3'b100, 40'h00_00C3B2A1), 0,
                  40'hC3B2A1, 3'b100};
      vecs[1] = '{mk(1, 3'b011, 3'b010, 40'h0504030201), 1,
                  40'h0504030201, 3'b010};
      vecs[2] = '{mk(0, 3'b011, 3'b001, 40'hDEAD5A6B7C), 0,
                  40'h5A6B7C, 3'b001};
      vecs[3] = '{mk(1, 3'b011, 3'b111, 40'hFF00807F01), 1,
                  40'hFF00807F01, 3'b111};
      vecs[4] = '{mk(0, ALT_DEST, 3'b110, 40'h0000123456), 0,
                  40'h123456, 3'b110};

      repeat (3) tick();
      rst = 1'b0;
      tick();

      mode = 0;
      for (int v = 0; v < 5; v++) begin
         send(vecs[v].pkt);
         if (!vecs[v].is_ifm) begin
            chk("vec_filt_valid", filt_valid, 1);
            chk("vec_filt_data", filt_data, vecs[v].exp[23:0]);
            chk("vec_src", pkt_src, vecs[v].src);
            tick();
            chk("vec_filt_ready2", in_ready, 1);
         end else begin
            for (int i = 0; i < NK; i++) begin
               chk("vec_ifm_valid", ifm_valid, 1);
               chk("vec_ifm_data", ifm_data, vecs[v].exp[8*i +: 8]);
               chk("vec_ifm_last", ifm_last, i == NK - 1);
               chk("vec_ifm_busy", in_ready, 0);
               tick();
            end
            chk("vec_ifm_done", in_ready, 1);
         end
      end

      mode = 1;
      h0 = hs_cnt;
      send(mk(1, 3'b011, 3'b010, 40'h0504030201));
      wait_idle();
      chk("toggle_handshakes", hs_cnt - h0, NK);

      mode = 0;
      send(mk(0, 3'b011, 3'b100, 40'h00_00A1B2C3));
      send(mk(1, 3'b011, 3'b101, 40'h1122334455));
      wait_idle();

      send(mk(1, 3'b011, 3'b011, 40'h0504030201));
      tick();
      tick();
      chk("pre_rst_byte2", ifm_data, 8'h03);
      rst = 1'b1;
      tick();
      chk("mid_rst_valids", {filt_valid, ifm_valid}, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_valids", {filt_valid, ifm_valid, ifm_data}, 0);
      send(mk(0, 3'b011, 3'b100, 40'h00_00C3B2A1));
      chk("post_rst_filt", filt_data, 24'hC3B2A1);
      wait_idle();

`ifdef DPE_ADDR_CHECK_EN
      send(mk(0, 3'b001, 3'b100, 40'h00_00778899));
      repeat (3) tick();
      chk("aerr_set", addr_err, 1);
      chk("aerr_no_out", {filt_valid, ifm_valid}, 0);
      send(mk(0, 3'b011, 3'b100, 40'h00_00C3B2A1));
      chk("aerr_good_filt", filt_data, 24'hC3B2A1);
      wait_idle();
      chk("aerr_sticky", addr_err, 1);
`endif

      mode = 2;
      for (int n = 0; n < 120; n++) begin
         pl = {8'($urandom), 32'($urandom)};
`ifdef DPE_ADDR_CHECK_EN
         dst = ($urandom_range(0, 3) == 0) ? 3'b001 : 3'b011;
`else
         dst = 3'($urandom);
`endif
         send(mk(1'($urandom_range(0, 1)), dst, 3'($urandom), pl));
         repeat ($urandom_range(0, 2)) tick();
      end
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
